// File: rtl/accum_seq.sv
// accum_seq: time-multiplexed ADPCM predictor accumulator (SEZ/SE).
//
// Accepts NZ zero-section partial products (WB terms) followed by NP
// pole-section partial products (WA terms), one per cycle over a
// valid/ready stream. Sums wrap modulo 2^W. When the frame completes,
// SEZ = (sum WB) >>> 1 and SE = (sum WB + sum WA) >>> 1 are presented
// together with the frame's channel tag until the downstream handshake.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous active-high reset, discards any partial frame
//   IN_VALID   input term valid
//   IN_READY   block accepts a term this cycle
//   IN_DATA    two's-complement partial product (WB first, then WA)
//   IN_CH      channel tag, sampled on the first term of a frame only
//   OUT_VALID  SEZ/SE/OUT_CH hold a completed frame
//   OUT_READY  downstream consumes the result
//   SEZ        zero-section estimate
//   SE         full signal estimate
//   OUT_CH     tag of the frame on SEZ/SE
module accum_seq #(
  parameter int W   = 16,
  parameter int NZ  = 6,
  parameter int NP  = 2,
  parameter int CHW = 5
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [W-1:0]   IN_DATA,
  input  logic [CHW-1:0] IN_CH,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [W-1:0]   SEZ,
  output logic [W-1:0]   SE,
  output logic [CHW-1:0] OUT_CH
);

  localparam int MAXT = (NZ > NP) ? NZ : NP;
  localparam int CNTW = $clog2(MAXT + 1);
  localparam logic [CNTW-1:0] NZ_LAST = CNTW'(NZ - 1);
  localparam logic [CNTW-1:0] NP_LAST = CNTW'(NP - 1);

  typedef enum logic [1:0] {
    ST_ZERO,
    ST_POLE,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sezi_q, sezi_d;
  logic [CHW-1:0]  tag_q, tag_d;
  logic [W-1:0]    sez_q, sez_d;
  logic [W-1:0]    se_q, se_d;
  logic [CHW-1:0]  out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;

  logic            in_fire;
  logic [W-1:0]    sum;

  // Ready is withheld while reset is asserted so no term is taken
  // into a frame that is being discarded.
  assign IN_READY  = (state_q != ST_DONE) && !RESET;
  assign in_fire   = IN_VALID && IN_READY;

  assign OUT_VALID = out_valid_q;
  assign SEZ       = sez_q;
  assign SE        = se_q;
  assign OUT_CH    = out_ch_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sezi_d      = sezi_q;
    tag_d       = tag_q;
    sez_d       = sez_q;
    se_d        = se_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sum         = '0;

    case (state_q)
      ST_ZERO: begin
        if (in_fire) begin
          // First term loads rather than adds, so no stale accumulator
          // value can leak into a new frame.
          sum = (cnt_q == '0) ? IN_DATA : acc_q + IN_DATA;
          acc_d = sum;
          if (cnt_q == '0) begin
            tag_d = IN_CH;
          end
          if (cnt_q == NZ_LAST) begin
            sezi_d  = sum;
            cnt_d   = '0;
            state_d = ST_POLE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      ST_POLE: begin
        if (in_fire) begin
          sum   = acc_q + IN_DATA;
          acc_d = sum;
          if (cnt_q == NP_LAST) begin
            sez_d       = {sezi_q[W-1], sezi_q[W-1:1]};
            se_d        = {sum[W-1], sum[W-1:1]};
            out_ch_d    = tag_q;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      ST_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ST_ZERO;
        end
      end

      default: begin
        state_d = ST_ZERO;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_ZERO;
      cnt_q       <= '0;
      acc_q       <= '0;
      sezi_q      <= '0;
      tag_q       <= '0;
      sez_q       <= '0;
      se_q        <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sezi_q      <= sezi_d;
      tag_q       <= tag_d;
      sez_q       <= sez_d;
      se_q        <= se_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_accum_seq.sv
// Testbench for accum_seq (W=16, NZ=6, NP=2, CHW=5): directed frames for
// the basic, sign-extension, wrap-around, backpressure and mid-frame reset
// cases, followed by randomized frames checked against an arithmetic
// reference model of the predictor sums.
module tb_accum_seq;

  localparam int NZ = 6;
  localparam int NP = 2;
  localparam int NT = NZ + NP;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic [4:0]  IN_CH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] SEZ;
  logic [15:0] SE;
  logic [4:0]  OUT_CH;

  int checks = 0;
  int errors = 0;

  logic [15:0] term_buf [NT];

  accum_seq #(.W(16), .NZ(NZ), .NP(NP), .CHW(5)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_CH     (IN_CH),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SEZ       (SEZ),
    .SE        (SE),
    .OUT_CH    (OUT_CH)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the sum modulo 2^16 as a signed value and take
  // floor(value / 2), which is what an arithmetic right shift by one means.
  function automatic logic [15:0] half_of(input int s);
    int v;
    v = s % 65536;
    if (v >= 32768) v = v - 65536;
    if (v >= 0) v = v / 2;
    else        v = -((-v + 1) / 2);
    return 16'(v);
  endfunction

  function automatic logic [15:0] model_sez();
    int s = 0;
    for (int i = 0; i < NZ; i++) s += int'(term_buf[i]);
    return half_of(s);
  endfunction

  function automatic logic [15:0] model_se();
    int s = 0;
    for (int i = 0; i < NT; i++) s += int'(term_buf[i]);
    return half_of(s);
  endfunction

  // Feed term_buf[0..n-1]; later terms carry a random tag that must be ignored.
  task automatic feed_terms(input int n, input logic [4:0] ch, input bit bubbles,
                            input bit expect_immediate);
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      if (bubbles) begin
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
      end
      IN_VALID = 1'b1;
      IN_DATA  = term_buf[i];
      IN_CH    = (i == 0) ? ch : 5'($urandom);
      while (IN_READY !== 1'b1 && budget < 20) begin
        @(posedge CLK); #1;
        budget++;
      end
      check("in_ready_wait", {31'd0, IN_READY}, 32'd1);
      if (i == 0 && expect_immediate) check("first_term_wait", budget, 0);
      @(posedge CLK); #1;
      if (i < n - 1) check("out_valid_early", {31'd0, OUT_VALID}, 32'd0);
    end
    IN_VALID = 1'b0;
    IN_DATA  = 16'hDEAD;
  endtask

  // Called right after the last term was accepted.
  task automatic drain(input int stall, input logic [4:0] ch);
    logic [15:0] esez, ese;
    esez = model_sez();
    ese  = model_se();
    OUT_READY = (stall == 0);
    check("out_valid_rise", {31'd0, OUT_VALID}, 32'd1);
    check("in_ready_done",  {31'd0, IN_READY},  32'd0);
    check("sez", {16'd0, SEZ}, {16'd0, esez});
    check("se",  {16'd0, SE},  {16'd0, ese});
    check("out_ch", {27'd0, OUT_CH}, {27'd0, ch});
    for (int k = 0; k < stall; k++) begin
      IN_VALID = 1'b1;
      @(posedge CLK); #1;
      check("stall_valid",    {31'd0, OUT_VALID}, 32'd1);
      check("stall_in_ready", {31'd0, IN_READY},  32'd0);
      check("stall_sez", {16'd0, SEZ}, {16'd0, esez});
      check("stall_se",  {16'd0, SE},  {16'd0, ese});
      check("stall_ch",  {27'd0, OUT_CH}, {27'd0, ch});
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check("out_valid_fall", {31'd0, OUT_VALID}, 32'd0);
    check("in_ready_after", {31'd0, IN_READY},  32'd1);
    check("hold_sez", {16'd0, SEZ}, {16'd0, esez});
    check("hold_se",  {16'd0, SE},  {16'd0, ese});
  endtask

  task automatic load_basic();
    for (int i = 0; i < NZ; i++) term_buf[i] = 16'h0010;
    term_buf[6] = 16'h0100;
    term_buf[7] = 16'h0100;
  endtask

  initial begin
    RESET     = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_CH     = '0;
    OUT_READY = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_sez", {16'd0, SEZ}, 32'd0);
    check("rst_se",  {16'd0, SE},  32'd0);
    check("rst_ch",  {27'd0, OUT_CH}, 32'd0);
    #3 RESET = 1'b0;
    @(posedge CLK); #1;
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);

    // Basic frame
    load_basic();
    OUT_READY = 1'b1;
    feed_terms(NT, 5'd3, 1'b0, 1'b1);
    drain(0, 5'd3);
    check("basic_sez_lit", {16'd0, SEZ}, 32'h0030);
    check("basic_se_lit",  {16'd0, SE},  32'h0130);

    // Negative sign extension
    term_buf[0] = 16'hFFF0;
    for (int i = 1; i < NT; i++) term_buf[i] = 16'h0000;
    feed_terms(NT, 5'd1, 1'b0, 1'b1);
    drain(0, 5'd1);
    check("neg_sez_lit", {16'd0, SEZ}, 32'hFFF8);
    check("neg_se_lit",  {16'd0, SE},  32'hFFF8);

    // Wrap-around
    for (int i = 0; i < NZ; i++) term_buf[i] = 16'h0001;
    term_buf[6] = 16'h7FFF;
    term_buf[7] = 16'h7FFF;
    feed_terms(NT, 5'd2, 1'b0, 1'b1);
    drain(0, 5'd2);
    check("wrap_sez_lit", {16'd0, SEZ}, 32'h0003);
    check("wrap_se_lit",  {16'd0, SE},  32'h0002);

    // Backpressure and bubbles, then tag-7 frame right after the handshake
    load_basic();
    feed_terms(NT, 5'd3, 1'b1, 1'b1);
    drain(5, 5'd3);
    for (int i = 0; i < NT; i++) term_buf[i] = 16'(i * 16'h0101);
    feed_terms(NT, 5'd7, 1'b0, 1'b1);
    drain(2, 5'd7);

    // Reset mid-frame
    load_basic();
    for (int i = 0; i < NZ; i++) term_buf[i] = 16'h0123;
    feed_terms(4, 5'd9, 1'b0, 1'b1);
    #2 RESET = 1'b1;
    #1;
    check("mrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("mrst_sez", {16'd0, SEZ}, 32'd0);
    check("mrst_se",  {16'd0, SE},  32'd0);
    check("mrst_ch",  {27'd0, OUT_CH}, 32'd0);
    #1 RESET = 1'b0;
    @(posedge CLK); #1;
    load_basic();
    feed_terms(NT, 5'd4, 1'b0, 1'b1);
    drain(0, 5'd4);
    check("mrst_sez_lit", {16'd0, SEZ}, 32'h0030);
    check("mrst_se_lit",  {16'd0, SE},  32'h0130);

    // Randomized frames against the reference model
    for (int f = 0; f < 60; f++) begin
      logic [4:0] ch;
      ch = 5'($urandom);
      for (int i = 0; i < NT; i++) begin
        case ($urandom_range(0, 3))
          0:       term_buf[i] = 16'($urandom_range(0, 255));
          1:       term_buf[i] = 16'hFFFF - 16'($urandom_range(0, 255));
          default: term_buf[i] = 16'($urandom);
        endcase
      end
      OUT_READY = 1'($urandom);
      feed_terms(NT, ch, 1'($urandom), 1'b1);
      drain($urandom_range(0, 3), ch);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_seq.md
Name: accum_seq

Overview:
- Time-multiplexed, parametrised successor to the combinational ADPCM predictor accumulator (SEZ/SE computation).
- Accepts the zero-section partial products (WB1..WBn) and pole-section partial products (WA1..WAm) one term per cycle over a valid/ready stream.
- Accumulates modulo 2^W and emits SEZ and SE, each the accumulated sum arithmetically shifted right by one.
- Carries a channel tag so one instance serves many interleaved codec channels between the FMULT stage and the reconstruction/quantiser stages.

Parameters:
- W, 16, data width of terms, sums and outputs.
- NZ, 6, zero-section terms per frame (WB count), >=1.
- NP, 2, pole-section terms per frame (WA count), >=1.
- CHW, 5, channel tag width (32 channels).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  term on IN_DATA is valid.
- IN_READY  output  1  block accepts a term this cycle.
- IN_DATA  input  W  two's-complement partial product (WB terms first, then WA terms).
- IN_CH  input  CHW  channel tag; sampled on the first term of a frame only.
- OUT_VALID  output  1  SE/SEZ/OUT_CH hold a completed frame.
- OUT_READY  input  1  downstream consumes the result.
- SEZ  output  W  zero-section estimate.
- SE  output  W  full signal estimate.
- OUT_CH  output  CHW  tag of the frame on SE/SEZ.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=ZERO, term counter=0, accumulator=0, OUT_VALID=0.
  - SEZ=0, SE=0, OUT_CH=0, IN_READY=1 once RESET deasserts.
  - Any partial frame is discarded.
- Transfer rules:
  - Input transfer occurs when IN_VALID && IN_READY.
  - Output transfer occurs when OUT_VALID && OUT_READY.
- States:
  - ZERO: IN_READY=1.
    - On a transfer: acc <= acc + IN_DATA (mod 2^W). The first term loads acc <= IN_DATA and latches IN_CH.
    - On the NZ-th transfer: latch SEZI = resulting sum, reset counter, go to POLE.
  - POLE: IN_READY=1.
    - On a transfer: acc <= acc + IN_DATA (mod 2^W).
    - On the NP-th transfer, load outputs and go to DONE:
      - SEZ <= SEZI >>> 1
      - SE <= (final sum) >>> 1
      - OUT_CH <= latched tag
      - OUT_VALID <= 1
  - DONE: IN_READY=0, outputs held stable.
    - On an output transfer: OUT_VALID <= 0, acc cleared, go to ZERO.
    - The next frame's first term is accepted the following cycle; no same-cycle pipelining.
- Arithmetic:
  - All additions wrap modulo 2^W; there is no saturation.
  - The shift is arithmetic: bit W-1 is replicated into the MSB.
  - Matches the combinational reference: SEZ = (sum WB)>>>1, SE = (sum WB + sum WA)>>>1.
- Latency: OUT_VALID rises the cycle after the last WA term is accepted. Minimum frame period is NZ+NP+1 cycles.
- IN_VALID low mid-frame: no state change; the counter holds indefinitely.
- IN_CH changes after the first term: ignored.
- OUT_READY high while OUT_VALID is low: no effect.
- SEZ/SE/OUT_CH keep their last frame's values after the handshake, until the next frame completes.
- Counter width: clog2(max(NZ,NP)+1). The counter must not wrap in either section.

Test Plan:
- Basic, W=16, NZ=6, NP=2:
  - Stimulus: WB1..6=0x0010 each, WA1=WA2=0x0100, IN_CH=3, OUT_READY=1.
  - Expected: SEZ=0x0030, SE=0x0130, OUT_CH=3; OUT_VALID high exactly 1 cycle after the 8th term; IN_READY low that cycle.
- Negative sign extension:
  - Stimulus: WB1=0xFFF0, WB2..6=0, WA1=WA2=0.
  - Expected: SEZ=0xFFF8, SE=0xFFF8.
- Wrap-around:
  - Stimulus: WB1..6=0x0001, WA1=WA2=0x7FFF.
  - Expected: sum=0x0004 mod 2^16, so SEZ=0x0003, SE=0x0002.
- Backpressure and bubbles:
  - Stimulus: same as Basic with IN_VALID toggled every other cycle and OUT_READY held low 5 cycles after OUT_VALID.
  - Expected: outputs stable for the whole stall; IN_READY=0 throughout; the next frame's (tag 7) first term is accepted the cycle after the OUT_READY handshake; its results are correct.
- Reset mid-frame:
  - Stimulus: assert RESET asynchronously after the 4th WB term, then feed a full fresh frame (Basic values).
  - Expected: immediate OUT_VALID=0, SE=SEZ=0; the fresh frame yields SEZ=0x0030, SE=0x0130 with no residue from the aborted frame.
- Regression against vectors:
  - Stimulus: stream the 19879-entry wa1/wa2/wb1..wb6 vector sets for all rates (40/32/24/16) and both laws (alaw/ulaw), serialised as WB then WA, random OUT_READY.
  - Expected: every SE/SEZ matches se.t/sez.t.
